// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the back-end stall/flush controller: stage indices,
// pause patterns, FSM encoding and reset defaults.
package pipeline_ctrl_pkg;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  localparam int ExceptionCauseWidth = 7;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  // A stall at stage k holds stage k and everything upstream of it.
  localparam logic [5:0] PAUSE_NONE = 6'b000000;
  localparam logic [5:0] PAUSE_IF   = 6'b000011;
  localparam logic [5:0] PAUSE_ID   = 6'b000111;
  localparam logic [5:0] PAUSE_EX   = 6'b001111;
  localparam logic [5:0] PAUSE_MEM  = 6'b011111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_pause_encoder.sv
// Priority encoder from per-stage stall requests to the pause vector;
// the most downstream requester wins.
module pipeline_ctrl_pause_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic       stall_req_if,
  input  logic       stall_req_id,
  input  logic       stall_req_ex,
  input  logic       stall_req_mem,
  output logic [5:0] pause
);

  always_comb begin
    pause = PAUSE_NONE;
    if (stall_req_mem)     pause = PAUSE_MEM;
    else if (stall_req_ex) pause = PAUSE_EX;
    else if (stall_req_id) pause = PAUSE_ID;
    else if (stall_req_if) pause = PAUSE_IF;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 6-stage back end with exception/ertn redirect.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_req_if,
  input  logic                           stall_req_id,
  input  logic                           stall_req_ex,
  input  logic                           stall_req_mem,
  input  logic                           mem_is_exception,
  input  logic [ExceptionCauseWidth-1:0] mem_exception_cause,
  input  logic [31:0]                    mem_pc,
  input  logic                           mem_is_ertn,
  input  logic [31:0]                    csr_eentry,
  input  logic [31:0]                    csr_era,
  output logic [5:0]                     pause,
  output logic                           exception_flush,
  output logic                           csr_exc_en,
  output logic [ExceptionCauseWidth-1:0] csr_exc_cause,
  output logic [31:0]                    csr_exc_pc,
  output logic                           csr_ertn_en,
  output logic                           new_pc_valid,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]               perf_stall_cycles,
  output logic [CNT_W-1:0]               perf_flush_count,
`endif
  output logic [31:0]                    new_pc
);

  state_t      state;
  logic [31:0] target;
  logic [5:0]  run_pause;
  logic        event_hit;

  pipeline_ctrl_pause_encoder u_pause_encoder (
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .pause         (run_pause)
  );

  // Exception/ertn inputs are only honoured in RUN; REDIRECT holds bubbles.
  assign event_hit = (mem_is_exception || mem_is_ertn) && (state == ST_RUN);

  always_comb begin
    pause           = PAUSE_NONE;
    exception_flush = 1'b0;
    csr_exc_en      = 1'b0;
    csr_exc_cause   = '0;
    csr_exc_pc      = '0;
    csr_ertn_en     = 1'b0;
    new_pc_valid    = 1'b0;
    if (state == ST_RUN) begin
      if (event_hit) begin
        exception_flush = 1'b1;
        if (mem_is_exception) begin
          csr_exc_en    = 1'b1;
          csr_exc_cause = mem_exception_cause;
          csr_exc_pc    = mem_pc;
        end else begin
          csr_ertn_en = 1'b1;
        end
      end else begin
        pause = run_pause;
      end
    end else begin
      // Wait for the in-flight fetch to retire before steering the front end.
      if (stall_req_if) pause = PAUSE_IF;
      else              new_pc_valid = 1'b1;
    end
  end

  assign new_pc = target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      target <= RESET_PC;
    end else begin
      case (state)
        ST_RUN: begin
          if (event_hit) begin
            target <= mem_is_exception ? csr_eentry : csr_era;
            state  <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (!stall_req_if) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if ((state == ST_RUN) && (pause != PAUSE_NONE))
        perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if (exception_flush)
        perf_flush_count <= perf_flush_count + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each cycle pushes the expected output
// vector while driving inputs and pops/compares it mid-cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        mem_is_exception, mem_is_ertn;
  logic [6:0]  mem_exception_cause;
  logic [31:0] mem_pc, csr_eentry, csr_era;
  logic [5:0]  pause;
  logic        exception_flush, csr_exc_en, csr_ertn_en, new_pc_valid;
  logic [6:0]  csr_exc_cause;
  logic [31:0] csr_exc_pc, new_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  int checks = 0;
  int errors = 0;
  logic [80:0] sb[$];
  logic [80:0] got, want;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_req_if        (stall_req_if),
    .stall_req_id        (stall_req_id),
    .stall_req_ex        (stall_req_ex),
    .stall_req_mem       (stall_req_mem),
    .mem_is_exception    (mem_is_exception),
    .mem_exception_cause (mem_exception_cause),
    .mem_pc              (mem_pc),
    .mem_is_ertn         (mem_is_ertn),
    .csr_eentry          (csr_eentry),
    .csr_era             (csr_era),
    .pause               (pause),
    .exception_flush     (exception_flush),
    .csr_exc_en          (csr_exc_en),
    .csr_exc_cause       (csr_exc_cause),
    .csr_exc_pc          (csr_exc_pc),
    .csr_ertn_en         (csr_ertn_en),
    .new_pc_valid        (new_pc_valid),
`ifdef PIPE_PERF_CNT_EN
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_flush_count    (perf_flush_count),
`endif
    .new_pc              (new_pc)
  );

  function automatic logic [80:0] expv(input logic [5:0] p, input logic fl, input logic ex,
                                       input logic [6:0] c, input logic [31:0] pc,
                                       input logic er, input logic nv, input logic [31:0] np);
    return {p, fl, ex, c, pc, er, nv, np};
  endfunction

  function automatic logic [80:0] obs();
    return {pause, exception_flush, csr_exc_en, csr_exc_cause, csr_exc_pc,
            csr_ertn_en, new_pc_valid, new_pc};
  endfunction

  task automatic drive(input logic sif, input logic sid, input logic sex, input logic smem,
                       input logic exc, input logic ertn, input logic [6:0] cause,
                       input logic [31:0] mpc);
    stall_req_if = sif; stall_req_id = sid; stall_req_ex = sex; stall_req_mem = smem;
    mem_is_exception = exc; mem_is_ertn = ertn;
    mem_exception_cause = cause; mem_pc = mpc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0);
    csr_eentry = 32'h0; csr_era = 32'h0;
    sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC));
    @(negedge clk);
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset got %h want %h", got, want);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (perf_stall_cycles !== 32'h0 || perf_flush_count !== 32'h0) begin
      errors++; $display("FAIL reset_perf got %h/%h want 0/0", perf_stall_cycles, perf_flush_count);
    end
`endif
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_stall();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      case (c)
        0, 1, 2: begin drive(1, 0, 1, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b001111, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC)); end
        4:       begin drive(0, 1, 0, 1, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b011111, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC)); end
        5:       begin drive(1, 1, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b000111, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC)); end
        6:       begin drive(1, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b000011, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b000000, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC)); end
      endcase
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall c%0d got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_exception();
    csr_eentry = 32'h1C00_8000; csr_era = 32'h1C00_0100;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(0, 0, 0, 0, 1, 0, 7'h0B, 32'h1C00_0040); sb.push_back(expv(6'b0, 1, 1, 7'h0B, 32'h1C00_0040, 0, 0, RST_PC)); end
        // exception input still high in REDIRECT must be ignored
        1: begin drive(0, 0, 0, 0, 1, 0, 7'h0B, 32'h1C00_0040); sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 1, 32'h1C00_8000)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_8000)); end
      endcase
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL exception c%0d got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_ertn();
    csr_eentry = 32'h1C00_9000; csr_era = 32'h1C00_0100;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(0, 1, 0, 0, 0, 1, 7'h0, 32'h1C00_0500); sb.push_back(expv(6'b0, 1, 0, 7'h0, 32'h0, 1, 0, 32'h1C00_8000)); end
        1: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0);         sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 1, 32'h1C00_0100)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0);   sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_0100)); end
      endcase
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL ertn c%0d got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_redirect_stall();
    csr_eentry = 32'h1C00_A000; csr_era = 32'h1C00_0200;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(1, 0, 0, 0, 1, 0, 7'h03, 32'h1C00_0080); sb.push_back(expv(6'b0, 1, 1, 7'h03, 32'h1C00_0080, 0, 0, 32'h1C00_0100)); end
        1, 3, 4: begin drive(1, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b000011, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_A000)); end
        // other requests and a new ertn are ignored while redirecting
        2: begin drive(1, 1, 1, 1, 0, 1, 7'h0, 32'h0); sb.push_back(expv(6'b000011, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_A000)); end
        5: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 1, 32'h1C00_A000)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_A000)); end
      endcase
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL redirect_stall c%0d got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_mem_stall_exception();
    csr_eentry = 32'h1C00_C000; csr_era = 32'h1C00_0300;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      case (c)
        // exception beats ertn and the mem stall
        0: begin drive(0, 0, 0, 1, 1, 1, 7'h15, 32'h1C00_0200); sb.push_back(expv(6'b0, 1, 1, 7'h15, 32'h1C00_0200, 0, 0, 32'h1C00_A000)); end
        1: begin drive(0, 0, 0, 1, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 1, 32'h1C00_C000)); end
        default: begin drive(0, 0, 0, 1, 0, 0, 7'h0, 32'h0); sb.push_back(expv(6'b011111, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_C000)); end
      endcase
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL mem_stall_exc c%0d got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_reset_redirect();
    csr_eentry = 32'h1C00_E000; csr_era = 32'h1C00_0400;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        drive(1, 0, 0, 0, 1, 0, 7'h01, 32'h1C00_0600);
        sb.push_back(expv(6'b0, 1, 1, 7'h01, 32'h1C00_0600, 0, 0, 32'h1C00_C000));
      end else begin
        drive(1, 0, 0, 0, 0, 0, 7'h0, 32'h0);
        sb.push_back(expv(6'b000011, 0, 0, 7'h0, 32'h0, 0, 0, 32'h1C00_E000));
      end
      @(negedge clk);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_redirect c%0d got %h want %h", c, got, want);
      end
    end
    stall_req_if = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (new_pc !== RST_PC) begin
      errors++; $display("FAIL async_reset_new_pc got %h want %h", new_pc, RST_PC);
    end
    checks++;
    if (new_pc_valid !== 1'b0 || exception_flush !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid got %b/%b want 0/0", new_pc_valid, exception_flush);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (perf_stall_cycles !== 32'h0 || perf_flush_count !== 32'h0) begin
      errors++; $display("FAIL async_reset_perf got %h/%h want 0/0", perf_stall_cycles, perf_flush_count);
    end
`endif
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 7'h0, 32'h0);
    sb.push_back(expv(6'b0, 0, 0, 7'h0, 32'h0, 0, 0, RST_PC));
    @(negedge clk);
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL post_reset_run got %h want %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_exception();
    test_ertn();
    test_redirect_stall();
    test_mem_stall_exception();
    test_reset_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
